// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: valid/ready front end for a single-port SRAM wrapper.
// Optional write acknowledges on the response stream: SRAM_WR_ACK_EN.
module sram_req_ctrl #(
   parameter int BITS         = 32,
   parameter int WORDS        = 1024,
   parameter int ADRESS_WIDTH = 10,
   parameter bit INIT_CLEAR   = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [ADRESS_WIDTH-1:0] req_addr,
   input  logic [BITS-1:0]         req_wdata,
   input  logic [BITS-1:0]         req_bmask,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [BITS-1:0]         rsp_rdata,
`ifdef SRAM_WR_ACK_EN
   output logic                    rsp_is_wr,
`endif
   output logic                    init_done,
   output logic [ADRESS_WIDTH-1:0] sram_adress,
   output logic                    sram_cen,
   output logic                    sram_wen,
   output logic [BITS-1:0]         sram_din,
   output logic [BITS-1:0]         sram_mask,
   input  logic [BITS-1:0]         sram_dout
);

   localparam logic [ADRESS_WIDTH:0] LIM =
      (ADRESS_WIDTH+1)'(WORDS);
   localparam logic [ADRESS_WIDTH-1:0] LAST =
      ADRESS_WIDTH'(WORDS-1);

   typedef enum logic {INIT, RUN} state_t;

   state_t                  state, state_nx;
   logic [ADRESS_WIDTH-1:0] cnt;
   logic                    in_range;
   logic                    accept;
   logic                    pend;
   logic                    pend_zero;
   logic                    push;
   logic                    pop;
   logic [1:0]              count;
   logic [2:0]              used;
   logic                    rd_ptr;
   logic                    wr_ptr;
   logic [BITS-1:0]         fifo_d [2];
`ifdef SRAM_WR_ACK_EN
   logic                    pend_wr;
   logic                    fifo_w [2];
`endif

   assign in_range  = {1'b0, req_addr} < LIM;
   assign push      = pend;
   assign rsp_valid = count != 2'd0;
   assign pop       = rsp_valid && rsp_ready;
   // An entry leaving this cycle frees its slot for a new issue.
   assign used      = 3'(count) + 3'(pend) - 3'(pop);
   assign req_ready = (state == RUN) && (used < 3'd2);
   assign accept    = req_valid && req_ready;
   assign init_done = state == RUN;
   assign rsp_rdata = fifo_d[rd_ptr];
`ifdef SRAM_WR_ACK_EN
   assign rsp_is_wr = fifo_w[rd_ptr];
`endif

   always_comb begin
      state_nx    = state;
      sram_cen    = 1'b1;
      sram_wen    = 1'b0;
      sram_adress = '0;
      sram_din    = '0;
      sram_mask   = '1;
      if (rst_n) begin
         unique case (state)
            INIT: begin
               if (INIT_CLEAR) begin
                  sram_cen    = 1'b0;
                  sram_wen    = 1'b1;
                  sram_mask   = '0;
                  sram_adress = cnt;
                  if (cnt == LAST) state_nx = RUN;
               end else begin
                  state_nx = RUN;
               end
            end
            RUN: begin
               if (accept && in_range) begin
                  sram_cen    = 1'b0;
                  sram_wen    = req_we;
                  sram_adress = req_addr;
                  sram_din    = req_wdata;
                  sram_mask   = req_we ? ~req_bmask : '1;
               end
            end
            default: state_nx = INIT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= INIT;
         cnt       <= '0;
         pend      <= 1'b0;
         pend_zero <= 1'b0;
`ifdef SRAM_WR_ACK_EN
         pend_wr   <= 1'b0;
`endif
      end else begin
         state <= state_nx;
         if (state == INIT) cnt <= cnt + ADRESS_WIDTH'(1);
`ifdef SRAM_WR_ACK_EN
         pend    <= accept;
         pend_wr <= req_we;
`else
         pend    <= accept && !req_we;
`endif
         pend_zero <= !in_range || req_we;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count     <= 2'd0;
         rd_ptr    <= 1'b0;
         wr_ptr    <= 1'b0;
         fifo_d[0] <= '0;
         fifo_d[1] <= '0;
`ifdef SRAM_WR_ACK_EN
         fifo_w[0] <= 1'b0;
         fifo_w[1] <= 1'b0;
`endif
      end else begin
         if (push) begin
            fifo_d[wr_ptr] <= pend_zero ? '0 : sram_dout;
`ifdef SRAM_WR_ACK_EN
            fifo_w[wr_ptr] <= pend_wr;
`endif
            wr_ptr <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + 2'(push) - 2'(pop);
      end
   end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// tb_sram_req_ctrl: randomized scoreboard bench for sram_req_ctrl.
// Reference: word array plus queue of expected responses.
module tb_sram_req_ctrl;

   localparam int W  = 16;
   localparam int AW = 5;

   logic          clk;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_wdata;
   logic [31:0]   req_bmask;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [31:0]   rsp_rdata;
   logic          init_done;
   logic [AW-1:0] sram_adress;
   logic          sram_cen;
   logic          sram_wen;
   logic [31:0]   sram_din;
   logic [31:0]   sram_mask;
   logic [31:0]   sram_dout;
`ifdef SRAM_WR_ACK_EN
   logic          rsp_is_wr;
`endif

   sram_req_ctrl #(
      .BITS(32), .WORDS(W), .ADRESS_WIDTH(AW), .INIT_CLEAR(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_bmask(req_bmask),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata),
`ifdef SRAM_WR_ACK_EN
      .rsp_is_wr(rsp_is_wr),
`endif
      .init_done(init_done),
      .sram_adress(sram_adress), .sram_cen(sram_cen),
      .sram_wen(sram_wen), .sram_din(sram_din),
      .sram_mask(sram_mask), .sram_dout(sram_dout)
   );

   typedef struct {
      logic [31:0] d;
      logic        w;
      int          c;
   } exp_t;

   exp_t        q [$];
   logic [31:0] ref_mem [W];
   logic [31:0] smem [W];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   logic        hold = 1'b0;
   logic [31:0] prev_d = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM wrapper model: masked write, one-cycle read latency.
   always @(posedge clk) begin
      if (!sram_cen) begin
         if (sram_wen)
            smem[sram_adress[3:0]] <=
               (smem[sram_adress[3:0]] & sram_mask) |
               (sram_din & ~sram_mask);
         else
            sram_dout <= smem[sram_adress[3:0]];
      end
   end

   task automatic chk(input string nm,
                      input logic [127:0] got,
                      input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   // Monitor: port checks, reference update, response scoreboard.
   always @(negedge clk) begin
      logic acc;
      logic inr;
      exp_t e;
      cyc++;
      if (!rst_n) begin
         hold = 1'b0;
      end else if (init_done) begin
         acc = req_valid && req_ready;
         inr = req_addr < AW'(W);
         if (acc && inr) begin
            chk("sram_port", {sram_cen, sram_wen, sram_adress, sram_mask},
                {1'b0, req_we, req_addr, req_we ? ~req_bmask : 32'hFFFF_FFFF});
            if (req_we) chk("sram_din", sram_din, req_wdata);
         end else begin
            chk("sram_idle", {sram_cen, sram_wen, sram_mask},
                {1'b1, 1'b0, 32'hFFFF_FFFF});
         end
         if (rsp_valid) begin
            if (hold) chk("rsp_stable", rsp_rdata, prev_d);
            if (rsp_ready) begin
               if (q.size() == 0) begin
                  chk("rsp_unexpected", rsp_valid, 1'b0);
               end else begin
                  e = q.pop_front();
                  chk("rsp_data", rsp_rdata, e.d);
`ifdef SRAM_WR_ACK_EN
                  chk("rsp_is_wr", rsp_is_wr, e.w);
`endif
                  chk("rsp_latency", cyc - e.c >= 2, 1'b1);
               end
            end
         end
         hold   = rsp_valid && !rsp_ready;
         prev_d = rsp_rdata;
         if (acc) begin
            e.c = cyc;
            e.w = req_we;
            e.d = '0;
            if (req_we) begin
               if (inr)
                  ref_mem[req_addr[3:0]] =
                     (ref_mem[req_addr[3:0]] & ~req_bmask) |
                     (req_wdata & req_bmask);
`ifdef SRAM_WR_ACK_EN
               q.push_back(e);
`endif
            end else begin
               if (inr) e.d = ref_mem[req_addr[3:0]];
               q.push_back(e);
            end
         end
      end
   end

   task automatic check_sweep();
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         chk("sweep", {sram_cen, sram_wen, sram_adress, sram_mask,
                       sram_din, init_done, req_ready},
             {1'b0, 1'b1, AW'(i), 32'h0, 32'h0, 1'b0, 1'b0});
      end
      @(negedge clk);
      chk("init_done", {init_done, sram_cen}, {1'b1, 1'b1});
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_a", {req_ready, rsp_valid, rsp_rdata, init_done},
          {1'b0, 1'b0, 32'h0, 1'b0});
      chk("rst_b", {sram_cen, sram_wen, sram_mask, sram_adress, sram_din},
          {1'b1, 1'b0, 32'hFFFF_FFFF, AW'(0), 32'h0});
      repeat (3) @(posedge clk);
      q.delete();
      for (int i = 0; i < W; i++) ref_mem[i] = '0;
      #1;
      rst_n = 1'b1;
      check_sweep();
   endtask

   task automatic issue(input logic we, input logic [AW-1:0] a,
                        input logic [31:0] d, input logic [31:0] m);
      logic ok;
      ok = 1'b0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      req_bmask = m;
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge clk);
         ok = req_ready;
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      chk("issue_timeout", ok, 1'b1);
   endtask

   task automatic drain();
      rsp_ready = 1'b1;
      for (int k = 0; k < 60 && q.size() != 0; k++) @(negedge clk);
      chk("drain", q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      logic acc;
      for (int i = 0; i < W; i++) smem[i] = $urandom;
      sram_dout = $urandom;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_bmask = '0;
      rsp_ready = 1'b1;
      do_reset();

      issue(1'b0, 5'd3, 32'h0, 32'h0);
      issue(1'b1, 5'd5, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
      repeat (3) @(posedge clk);
      #1;
      issue(1'b0, 5'd5, 32'h0, 32'h0);
      @(negedge clk);
      chk("lat_t1", rsp_valid, 1'b0);
      @(negedge clk);
      chk("lat_t2", rsp_valid, 1'b1);
      @(posedge clk);
      #1;

      issue(1'b1, 5'd7, 32'h1234_5678, 32'hFFFF_FFFF);
      issue(1'b1, 5'd7, 32'hFFFF_0000, 32'h0000_FFFF);
      issue(1'b0, 5'd7, 32'h0, 32'h0);
      drain();

      for (int i = 1; i <= 4; i++)
         issue(1'b1, AW'(i), 32'h1111_1111 * i, 32'hFFFF_FFFF);
      drain();
      rsp_ready = 1'b0;
      n = 0;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 5'd1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (req_ready) n++;
         @(posedge clk);
         #1;
         req_addr = AW'(n + 1);
      end
      @(negedge clk);
      chk("stall_accepts", n, 2);
      chk("stall_ready", req_ready, 1'b0);
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      for (int k = 0; k < 50 && n < 4; k++) begin
         @(negedge clk);
         if (req_ready) n++;
         @(posedge clk);
         #1;
         if (n >= 4) req_valid = 1'b0;
         else req_addr = AW'(n + 1);
      end
      req_valid = 1'b0;
      chk("stall_total", n, 4);
      drain();

      issue(1'b0, AW'(W), 32'h0, 32'h0);
      issue(1'b1, AW'(W), 32'hA5A5_A5A5, 32'hFFFF_FFFF);
      issue(1'b0, 5'd0, 32'h0, 32'h0);
      drain();

      rsp_ready = 1'b0;
      issue(1'b0, 5'd5, 32'h0, 32'h0);
      issue(1'b0, 5'd7, 32'h0, 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("queued", rsp_valid, 1'b1);
      @(posedge clk);
      #3;
      rsp_ready = 1'b1;
      do_reset();

      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         acc = req_valid && req_ready;
         @(posedge clk);
         #1;
         rsp_ready = $urandom_range(0, 3) != 0;
         if (!req_valid || acc) begin
            req_valid = $urandom_range(0, 2) != 0;
            req_we    = $urandom_range(0, 1) == 1;
            req_addr  = AW'($urandom_range(0, W));
            req_wdata = $urandom;
            req_bmask = ($urandom_range(0, 1) == 1) ?
                        32'hFFFF_FFFF : $urandom;
         end
      end
      req_valid = 1'b0;
      drain();
      for (int i = 0; i < W; i++)
         issue(1'b0, AW'(i), 32'h0, 32'h0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
